// File: rtl/dec_skid_pkg.sv
// Shared types and helpers for the dec_skid index decoder.
// Contents: the skid FSM state encoding and an index-width helper.
// Optional feature macro: DEC_SKID_THERMO_EN (adds a thermometer mask alongside sel).
// The entry struct depends on W, so each module declares it locally with this layout:
//   sel (W bits), err (1 bit), mask (W bits, DEC_SKID_THERMO_EN only).
package dec_skid_pkg;

  // Skid FSM state: number of valid entries held (0, 1 or 2).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Encoded index width for a W-wide one-hot; at least one bit.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/dec_skid_dec.sv
// Combinational binary-to-one-hot decoder with out-of-range detection.
// Ports:
//   idx  - encoded index
//   sel  - one-hot decode, all-zero when idx >= W
//   err  - idx >= W (only possible when W is not a power of two)
//   mask - (DEC_SKID_THERMO_EN only) bit i = (i < idx), all-ones on err
module dec_skid_dec
  import dec_skid_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned IDX_W = idx_width(W)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     sel,
`ifdef DEC_SKID_THERMO_EN
  output logic [W-1:0]     mask,
`endif
  output logic             err
);

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx);

  // Decode; an out-of-range index never matches any sel bit.
  always_comb begin
    sel = '0;
    err = (idx_ext >= W);
`ifdef DEC_SKID_THERMO_EN
    mask = '0;
`endif
    for (int i = 0; i < int'(W); i++) begin
      sel[i] = (idx_ext == 32'(i));
`ifdef DEC_SKID_THERMO_EN
      mask[i] = err | (idx_ext > 32'(i));
`endif
    end
  end

endmodule

// File: rtl/dec_skid.sv
// Registered binary-to-one-hot decoder with a two-entry skid buffer.
// Full throughput with in_rdy_o driven only from registered state.
// Optional feature macro: DEC_SKID_THERMO_EN adds out_mask_o (thermometer of idx).
// Ports:
//   clk, arst_n  - clock, asynchronous active-low reset
//   in_vld_i     - input index valid
//   in_idx_i     - encoded index (IDX_W bits)
//   in_rdy_o     - block can accept (registered)
//   out_vld_o    - output valid
//   out_sel_o    - one-hot decode of accepted index
//   out_err_o    - accepted index was >= W; out_sel_o is zero
//   out_mask_o   - (DEC_SKID_THERMO_EN) bit i = (i < idx); all-ones on err
//   out_rdy_i    - downstream accepts
module dec_skid
  import dec_skid_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned IDX_W = idx_width(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_vld_i,
  input  logic [IDX_W-1:0] in_idx_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [W-1:0]     out_sel_o,
  output logic             out_err_o,
`ifdef DEC_SKID_THERMO_EN
  output logic [W-1:0]     out_mask_o,
`endif
  input  logic             out_rdy_i
);

  typedef struct packed {
    logic [W-1:0] sel;
    logic         err;
`ifdef DEC_SKID_THERMO_EN
    logic [W-1:0] mask;
`endif
  } entry_t;

  state_t state_q;
  state_t state_d;
  logic   rdy_q;
  logic   vld_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec_entry;

  logic accept;
  logic xfer;
  logic load_main;
  logic load_skid;
  logic move_skid;
  logic clear_main;

  // Input-side decode.
  dec_skid_dec #(
    .W (W)
  ) u_dec (
    .idx  (in_idx_i),
    .sel  (dec_entry.sel),
`ifdef DEC_SKID_THERMO_EN
    .mask (dec_entry.mask),
`endif
    .err  (dec_entry.err)
  );

  assign accept = in_vld_i & rdy_q;
  assign xfer   = vld_q & out_rdy_i;

  // State register; ready/valid flops track the next state so they stay registered.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
      vld_q   <= (state_d != EMPTY);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = BUSY;
      BUSY: begin
        if (accept && !xfer)      state_d = FULL;
        else if (!accept && xfer) state_d = EMPTY;
      end
      FULL:  if (xfer) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
  end

  // Datapath controls per state.
  always_comb begin
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    clear_main = 1'b0;
    case (state_q)
      EMPTY: load_main = accept;
      BUSY: begin
        load_main  = accept & xfer;
        load_skid  = accept & ~xfer;
        clear_main = ~accept & xfer;
      end
      FULL:  move_skid = xfer;
      default: clear_main = 1'b1;
    endcase
  end

  // Main entry drives the outputs; cleared when the buffer drains.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= dec_entry;
    end else if (move_skid) begin
      main_q <= skid_q;
    end else if (clear_main) begin
      main_q <= '0;
    end
  end

  // Skid entry absorbs the one accept that lands while main is stalled.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= dec_entry;
    end
  end

  assign in_rdy_o   = rdy_q;
  assign out_vld_o  = vld_q;
  assign out_sel_o  = main_q.sel;
  assign out_err_o  = main_q.err;
`ifdef DEC_SKID_THERMO_EN
  assign out_mask_o = main_q.mask;
`endif

endmodule

// File: tb/tb_dec_skid.sv
// Directed self-checking bench for dec_skid (W=8 and W=5 instances).
module tb_dec_skid;

  logic       clk;
  logic       arst_n;

  logic       vld8, rdy8, in_rdy8, out_vld8, err8;
  logic [2:0] idx8;
  logic [7:0] sel8;
  logic       vld5, rdy5, in_rdy5, out_vld5, err5;
  logic [2:0] idx5;
  logic [4:0] sel5;
`ifdef DEC_SKID_THERMO_EN
  logic [7:0] mask8;
  logic [4:0] mask5;
`endif

  int n_vec;
  int n_err;

  logic [7:0] exp_stream [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  dec_skid #(.W(8)) u_dut8 (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_vld_i  (vld8),
    .in_idx_i  (idx8),
    .in_rdy_o  (in_rdy8),
    .out_vld_o (out_vld8),
    .out_sel_o (sel8),
    .out_err_o (err8),
`ifdef DEC_SKID_THERMO_EN
    .out_mask_o(mask8),
`endif
    .out_rdy_i (rdy8)
  );

  dec_skid #(.W(5)) u_dut5 (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_vld_i  (vld5),
    .in_idx_i  (idx5),
    .in_rdy_o  (in_rdy5),
    .out_vld_o (out_vld5),
    .out_sel_o (sel5),
    .out_err_o (err5),
`ifdef DEC_SKID_THERMO_EN
    .out_mask_o(mask5),
`endif
    .out_rdy_i (rdy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at the falling edge, observe 1 time unit after the rising edge.
  task automatic step8(input logic v, input logic [2:0] idx, input logic r);
    @(negedge clk);
    vld8 = v; idx8 = idx; rdy8 = r;
    @(posedge clk); #1;
  endtask

  task automatic step5(input logic v, input logic [2:0] idx, input logic r);
    @(negedge clk);
    vld5 = v; idx5 = idx; rdy5 = r;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #7 arst_n = 1'b0;
    #1;
    n_vec++;
    if (in_rdy8 !== 1'b1 || out_vld8 !== 1'b0 || sel8 !== 8'h00 || err8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_immediate: rdy=%b vld=%b sel=%h err=%b, want 1 0 00 0", in_rdy8, out_vld8, sel8, err8);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (in_rdy8 !== 1'b1 || out_vld8 !== 1'b0 || in_rdy5 !== 1'b1 || out_vld5 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: rdy8=%b vld8=%b rdy5=%b vld5=%b, want 1 0 1 0", c, in_rdy8, out_vld8, in_rdy5, out_vld5);
      end
    end
    @(negedge clk) arst_n = 1'b1;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 8; k++) begin
      step8(1'b1, 3'(k), 1'b1);
      n_vec++;
      if (out_vld8 !== 1'b1 || sel8 !== exp_stream[k] || err8 !== 1'b0 || in_rdy8 !== 1'b1) begin
        n_err++;
        $display("FAIL stream[%0d]: vld=%b sel=%h err=%b rdy=%b, want 1 %h 0 1", k, out_vld8, sel8, err8, in_rdy8, exp_stream[k]);
      end
    end
    step8(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (out_vld8 !== 1'b0 || sel8 !== 8'h00 || in_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL stream_drain: vld=%b sel=%h rdy=%b, want 0 00 1", out_vld8, sel8, in_rdy8);
    end
  endtask

  task automatic test_backpressure();
    step8(1'b1, 3'd3, 1'b0);
    n_vec++;
    if (out_vld8 !== 1'b1 || sel8 !== 8'h08 || in_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first: vld=%b sel=%h rdy=%b, want 1 08 1", out_vld8, sel8, in_rdy8);
    end
    step8(1'b1, 3'd5, 1'b0);
    n_vec++;
    if (out_vld8 !== 1'b1 || sel8 !== 8'h08 || in_rdy8 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: vld=%b sel=%h rdy=%b, want 1 08 0", out_vld8, sel8, in_rdy8);
    end
    // Offered while FULL: must not be accepted.
    step8(1'b1, 3'd7, 1'b0);
    n_vec++;
    if (out_vld8 !== 1'b1 || sel8 !== 8'h08 || in_rdy8 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_hold: vld=%b sel=%h rdy=%b, want 1 08 0", out_vld8, sel8, in_rdy8);
    end
    step8(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (out_vld8 !== 1'b1 || sel8 !== 8'h20 || in_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: vld=%b sel=%h rdy=%b, want 1 20 1", out_vld8, sel8, in_rdy8);
    end
    step8(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (out_vld8 !== 1'b0 || sel8 !== 8'h00 || in_rdy8 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain: vld=%b sel=%h rdy=%b, want 0 00 1", out_vld8, sel8, in_rdy8);
    end
  endtask

  task automatic test_error_index();
    logic [2:0] idx_v [4] = '{3'd6, 3'd4, 3'd5, 3'd0};
    logic [4:0] sel_v [4] = '{5'b00000, 5'b10000, 5'b00000, 5'b00001};
    logic       err_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step5(1'b1, idx_v[k], 1'b1);
      n_vec++;
      if (out_vld5 !== 1'b1 || sel5 !== sel_v[k] || err5 !== err_v[k]) begin
        n_err++;
        $display("FAIL err_idx[%0d]: vld=%b sel=%b err=%b, want 1 %b %b", k, out_vld5, sel5, err5, sel_v[k], err_v[k]);
      end
    end
    step5(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (out_vld5 !== 1'b0 || err5 !== 1'b0) begin
      n_err++;
      $display("FAIL err_drain: vld=%b err=%b, want 0 0", out_vld5, err5);
    end
  endtask

  task automatic test_reset_full();
    step8(1'b1, 3'd1, 1'b0);
    step8(1'b1, 3'd6, 1'b0);
    n_vec++;
    if (in_rdy8 !== 1'b0 || sel8 !== 8'h02) begin
      n_err++;
      $display("FAIL rf_prefill: rdy=%b sel=%h, want 0 02", in_rdy8, sel8);
    end
    @(negedge clk);
    vld8 = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    n_vec++;
    if (out_vld8 !== 1'b0 || in_rdy8 !== 1'b1 || sel8 !== 8'h00) begin
      n_err++;
      $display("FAIL rf_reset: vld=%b rdy=%b sel=%h, want 0 1 00", out_vld8, in_rdy8, sel8);
    end
    @(negedge clk) arst_n = 1'b1;
    step8(1'b1, 3'd2, 1'b1);
    n_vec++;
    if (out_vld8 !== 1'b1 || sel8 !== 8'h04) begin
      n_err++;
      $display("FAIL rf_after: vld=%b sel=%h, want 1 04", out_vld8, sel8);
    end
    step8(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (out_vld8 !== 1'b0 || sel8 !== 8'h00) begin
      n_err++;
      $display("FAIL rf_no_stale: vld=%b sel=%h, want 0 00", out_vld8, sel8);
    end
  endtask

`ifdef DEC_SKID_THERMO_EN
  task automatic test_thermo();
    step8(1'b1, 3'd3, 1'b1);
    n_vec++;
    if (mask8 !== 8'h07 || sel8 !== 8'h08) begin
      n_err++;
      $display("FAIL thermo_3: mask=%h sel=%h, want 07 08", mask8, sel8);
    end
    step8(1'b1, 3'd0, 1'b1);
    n_vec++;
    if (mask8 !== 8'h00 || sel8 !== 8'h01) begin
      n_err++;
      $display("FAIL thermo_0: mask=%h sel=%h, want 00 01", mask8, sel8);
    end
    step8(1'b0, 3'd0, 1'b1);
    step5(1'b1, 3'd7, 1'b1);
    n_vec++;
    if (mask5 !== 5'b11111 || err5 !== 1'b1 || sel5 !== 5'b00000) begin
      n_err++;
      $display("FAIL thermo_err: mask=%b err=%b sel=%b, want 11111 1 00000", mask5, err5, sel5);
    end
    step5(1'b0, 3'd0, 1'b1);
    n_vec++;
    if (mask5 !== 5'b00000 || out_vld5 !== 1'b0) begin
      n_err++;
      $display("FAIL thermo_drain: mask=%b vld=%b, want 00000 0", mask5, out_vld5);
    end
  endtask
`endif

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    arst_n = 1'b1;
    vld8 = 1'b0; idx8 = '0; rdy8 = 1'b0;
    vld5 = 1'b0; idx5 = '0; rdy5 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_error_index();
    test_reset_full();
`ifdef DEC_SKID_THERMO_EN
    test_thermo();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
